riscv_core_mc: RTL and testbench
================================

# riscv_core_mc

Multi-cycle, parametrised successor to the single-cycle core. It executes a small RV32I subset (ALU reg/imm, LW, SW, BEQ/BNE) through a FETCH/EXEC/MEM state machine. Data accesses use a request/grant handshake on the shared bus, and the core stalls in MEM until the arbiter grants. It adds load-data return, branches, per-core address windowing and an illegal/misaligned halt, and is instantiated once per core alongside the arbiter.

## Interface
Parameters:
- CORE_ID, 0: core index; selects the data address window.
- CORE_STRIDE, 32'h4: byte offset between core windows. Window offset = CORE_ID*CORE_STRIDE (32-bit, wraps).
- RESET_PC, 32'h0: PC value after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  instruction address; equals pc.
- imem_rdata  in  32  instruction word; combinational from imem_addr, valid in FETCH.
- bus_req  out  1  data bus request; high only in MEM.
- bus_grant  in  1  arbiter grant; transfer completes on a rising edge where bus_req && bus_grant.
- bus_we  out  1  1 = store, 0 = load; valid while bus_req.
- bus_addr  out  32  word address; 0 when not in MEM.
- bus_wdata  out  32  store data; 0 when not a store in MEM.
- bus_rdata  in  32  load data; sampled on the grant edge.
- retire  out  1  high for the single cycle in which an instruction completes.
- halted  out  1  high in HALT; sticky until reset.

## Operation
- State flow:
  - FETCH→EXEC: IR <= imem_rdata.
  - EXEC→FETCH: ALU ops and branches.
  - EXEC→MEM: legal, aligned LW/SW.
  - EXEC→HALT: illegal opcode/funct, misaligned data address, or misaligned branch target.
  - MEM→FETCH: on grant.
  - HALT: absorbing.
- Supported instructions (anything else is illegal):
  - OP-IMM (0010011), funct3 000/100/110/111: ADDI/XORI/ORI/ANDI.
  - OP (0110011):
    - funct7 0000000, funct3 000/100/110/111: ADD/XOR/OR/AND.
    - funct7 0100000, funct3 000: SUB.
  - LW: 0000011 with funct3 010.
  - SW: 0100011 with funct3 010.
  - BEQ/BNE: 1100011 with funct3 000/001.
- Immediates are sign-extended I/S/B formats; B immediate bit0 = 0.
- Register file: 32x32, two async reads, one sync write. x0 reads 0 and writes to it are discarded.
- ALU ops write rd and set pc += 4 in EXEC.
- Branches: pc = taken ? pc+imm_b : pc+4. No rd write.
- Effective address = rs1 + imm + CORE_ID*CORE_STRIDE, modulo 2^32. bits[1:0] != 0 → HALT with no request issued.
- At the EXEC→MEM edge, bus_addr/bus_we/bus_wdata (= rs2 for SW) are registered. They stay stable for the whole MEM state.
- MEM completion on grant:
  - SW: nothing written.
  - LW: rd <= bus_rdata.
  - Both: pc += 4, then → FETCH.
- HALT: pc holds the offending instruction's address. bus_req = 0, retire = 0, halted = 1.
- Arithmetic is 32-bit wrap, with no overflow detection.

## Timing
- Reset values (asynchronous, immediate):
  - pc = imem_addr = RESET_PC; state = FETCH.
  - All registers 0.
  - bus_req = bus_we = 0; bus_addr = bus_wdata = 0.
  - retire = 0; halted = 0.
- Latency:
  - ALU/branch: 2 cycles (FETCH, EXEC).
  - LW/SW: 3 + W cycles, where W = cycles in MEM with bus_grant low.
- retire is combinational from state: high in EXEC for ALU/branch, and in the MEM grant cycle for LW/SW.
- Handshake:
  - bus_req rises on the edge entering MEM and falls on the edge after the grant cycle.
  - While waiting, no output changes; bus_grant may toggle freely.
  - bus_grant outside MEM is ignored.
- Back-to-back memory instructions deassert bus_req for at least 2 cycles (FETCH, EXEC).
- Reset mid-MEM: bus_req drops asynchronously and no register or memory update occurs.
- Load hazards are absent, because the write completes before the next FETCH.

## Test plan
- Reset: hold reset with RESET_PC=32'h40 → imem_addr=0x40 and all bus outputs 0. After release, the first EXEC occurs on the 2nd edge.
- ALU + store, CORE_ID=2, grant tied high:
  - Program: ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2; SW x3,0(x0).
  - Expected: bus_addr=0x8, bus_we=1, bus_wdata=0x7, retire count 4 after 9 cycles.
- Delayed grant:
  - Program: LW x4,0x10(x0) with grant low for 3 MEM cycles, bus_rdata=0xDEADBEEF; then SW x4,0(x0).
  - Expected: bus_req/addr stable for 4 cycles and pc frozen; the store shows wdata 0xDEADBEEF.
- Branch loop:
  - Program: x1=3; loop ADDI x1,x1,-1; BNE x1,x0,-4.
  - Expected: exactly 3 taken/not-taken iterations, then fallthrough at loop+8. ADD x0,x1,x1 leaves x0=0 (verified via SW x0).
- Halt cases:
  - Word 0x00000073 → halted=1 and pc stays at its address.
  - LW from address 0x2 → halted=1 with bus_req never asserted.
  - A subsequent reset clears halted.
- Reset during a wait: assert reset in MEM with grant low → bus_req falls the same cycle. After release, execution restarts at RESET_PC with the load's rd still 0.

Source files
------------

// File: rtl/riscv_core_mc_if.sv
// Shared data-bus port bundle between one core (master) and the arbiter (slave).
// A transfer completes on a rising edge where bus_req && bus_grant.
interface riscv_core_mc_if;
  logic        bus_req;
  logic        bus_grant;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_grant, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_grant, bus_rdata
  );
endinterface

// File: rtl/riscv_core_mc.sv
// Multi-cycle RV32I subset core (ALU reg/imm, LW/SW, BEQ/BNE) with a FETCH/EXEC/MEM
// state machine, request/grant data bus, per-core address window and sticky HALT.
module riscv_core_mc #(
  parameter int          CORE_ID     = 0,
  parameter logic [31:0] CORE_STRIDE = 32'h4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  riscv_core_mc_if.master bus,
  output logic            retire,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] WINDOW_OFFSET = CORE_STRIDE * 32'(CORE_ID);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] ir;
  logic [31:0] regs [32];

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        mem_capture;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b;

  logic        alu_f3_ok;
  logic        legal_op_imm, legal_op, legal_load, legal_store, legal_branch;
  logic [31:0] alu_b, alu_result;
  logic [31:0] eff_addr;
  logic [31:0] pc_plus4, br_target;
  logic        br_taken;

  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign alu_f3_ok    = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);
  assign legal_op_imm = (opcode == OPC_OP_IMM) && alu_f3_ok;
  assign legal_op     = (opcode == OPC_OP) &&
                        (((funct7 == 7'b0000000) && alu_f3_ok) ||
                         ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign legal_load   = (opcode == OPC_LOAD)   && (funct3 == 3'b010);
  assign legal_store  = (opcode == OPC_STORE)  && (funct3 == 3'b010);
  assign legal_branch = (opcode == OPC_BRANCH) && (funct3[2:1] == 2'b00);

  assign eff_addr  = rs1_val + (legal_store ? imm_s : imm_i) + WINDOW_OFFSET;
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc + imm_b;
  assign br_taken  = (rs1_val == rs2_val) ^ funct3[0];

  // SUB only exists in the register form, so funct7[5] is ignored for OP-IMM.
  always_comb begin
    alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    case (funct3)
      3'b000:  alu_result = ((opcode == OPC_OP) && funct7[5]) ? rs1_val - alu_b
                                                               : rs1_val + alu_b;
      3'b100:  alu_result = rs1_val ^ alu_b;
      3'b110:  alu_result = rs1_val | alu_b;
      default: alu_result = rs1_val & alu_b;
    endcase
  end

  // Next-state, pc update, register write and retire all come from the current state.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    rf_we       = 1'b0;
    rf_wdata    = alu_result;
    mem_capture = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (legal_op_imm || legal_op) begin
          rf_we      = 1'b1;
          pc_next    = pc_plus4;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (legal_branch) begin
          if (br_taken && (br_target[1:0] != 2'b00)) begin
            state_next = S_HALT;
          end else begin
            pc_next    = br_taken ? br_target : pc_plus4;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (legal_load || legal_store) begin
          if (eff_addr[1:0] != 2'b00) begin
            state_next = S_HALT;
          end else begin
            mem_capture = 1'b1;
            state_next  = S_MEM;
          end
        end else begin
          state_next = S_HALT;
        end
      end
      S_MEM: begin
        if (bus.bus_grant) begin
          retire     = 1'b1;
          pc_next    = pc_plus4;
          state_next = S_FETCH;
          if (!mem_we_q) begin
            rf_we    = 1'b1;
            rf_wdata = bus.bus_rdata;
          end
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  // The bus request is frozen at EXEC->MEM so nothing moves while the arbiter stalls us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH) begin
        ir <= imem_rdata;
      end
      if (mem_capture) begin
        mem_addr_q  <= eff_addr;
        mem_we_q    <= legal_store;
        mem_wdata_q <= legal_store ? rs2_val : 32'h0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (rf_we && (rd != 5'd0)) begin
      regs[rd] <= rf_wdata;
    end
  end

  assign imem_addr     = pc;
  assign halted        = (state == S_HALT);
  assign bus.bus_req   = (state == S_MEM);
  assign bus.bus_we    = (state == S_MEM) && mem_we_q;
  assign bus.bus_addr  = (state == S_MEM) ? mem_addr_q : 32'h0;
  assign bus.bus_wdata = ((state == S_MEM) && mem_we_q) ? mem_wdata_q : 32'h0;

endmodule

// File: tb/tb_riscv_core_mc.sv
// Scoreboard bench for riscv_core_mc: an instruction-level reference model queues the
// expected retire/bus/halt events, and a negedge monitor pops and compares them.
module tb_riscv_core_mc;

  localparam int          CORE_ID     = 2;
  localparam logic [31:0] CORE_STRIDE = 32'h4;
  localparam logic [31:0] RESET_PC    = 32'h40;
  localparam logic [31:0] WIN         = 32'(CORE_ID) * CORE_STRIDE;
  localparam logic [31:0] ECALL       = 32'h0000_0073;

  typedef struct {
    logic [31:0] pc;
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        halt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        halted;

  riscv_core_mc_if bus_if ();

  riscv_core_mc #(
    .CORE_ID    (CORE_ID),
    .CORE_STRIDE(CORE_STRIDE),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .bus       (bus_if),
    .retire    (retire),
    .halted    (halted)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem   [logic [31:0]];
  logic [31:0] m_dmem [logic [31:0]];
  exp_t        sb [$];
  exp_t        mon_e;

  int          n_vec, n_err;
  int          retire_cnt;
  int          prog_ptr;
  logic        checking, halt_seen;
  logic [31:0] halt_pc;
  logic        rand_wait, stall_loads, in_txn;
  int          wait_target, wait_cnt, cur_wait;

  assign imem_rdata = imem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : fill_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string info);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: %s (t=%0t)", name, info, $time);
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] opc);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(input int rd, input int imm, input int rs1);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  function automatic logic [2:0] pick_f3();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b100;
      2:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = ECALL;
    dmem.delete();
    m_dmem.delete();
    prog_ptr = int'(RESET_PC[9:2]);
  endtask

  task automatic emit(input logic [31:0] w);
    imem[prog_ptr] = w;
    prog_ptr++;
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    dmem[a]   = v;
    m_dmem[a] = v;
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x,
                                      input logic [31:0] y, input logic sub);
    case (f3)
      3'b000:  return sub ? x - y : x + y;
      3'b100:  return x ^ y;
      3'b110:  return x | y;
      default: return x & y;
    endcase
  endfunction

  // Instruction-set reference model: runs the whole program up to its halt.
  task automatic iss_run();
    logic [31:0] r [32];
    logic [31:0] pc, npc, ir, a, b, ea, res, immi, imms, immb, tgt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok, wr, taken;
    int          rdi;
    exp_t        e;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    pc = RESET_PC;
    for (int step = 0; step < 4000; step++) begin
      ir   = imem[pc[9:2]];
      f3   = ir[14:12];
      f7   = ir[31:25];
      rdi  = int'(ir[11:7]);
      a    = r[ir[19:15]];
      b    = r[ir[24:20]];
      immi = 32'($signed(ir[31:20]));
      imms = 32'($signed({ir[31:25], ir[11:7]}));
      immb = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      e.pc = pc; e.is_mem = 1'b0; e.we = 1'b0; e.addr = 32'h0; e.wdata = 32'h0; e.halt = 1'b0;
      ok = 1'b0; wr = 1'b0; res = 32'h0; npc = pc + 4;
      case (ir[6:0])
        7'b0010011: if (f3 inside {3'd0, 3'd4, 3'd6, 3'd7}) begin
          res = alu(f3, a, immi, 1'b0); wr = 1'b1; ok = 1'b1;
        end
        7'b0110011: if ((f7 == 7'h00 && (f3 inside {3'd0, 3'd4, 3'd6, 3'd7})) ||
                        (f7 == 7'h20 && f3 == 3'd0)) begin
          res = alu(f3, a, b, f7 == 7'h20); wr = 1'b1; ok = 1'b1;
        end
        7'b0000011: if (f3 == 3'd2) begin
          ea = a + immi + WIN;
          if (ea % 4 == 0) begin
            e.is_mem = 1'b1; e.addr = ea;
            res = m_dmem.exists(ea) ? m_dmem[ea] : fill_word(ea);
            wr = 1'b1; ok = 1'b1;
          end
        end
        7'b0100011: if (f3 == 3'd2) begin
          ea = a + imms + WIN;
          if (ea % 4 == 0) begin
            e.is_mem = 1'b1; e.we = 1'b1; e.addr = ea; e.wdata = b;
            m_dmem[ea] = b; ok = 1'b1;
          end
        end
        7'b1100011: if (f3 <= 3'd1) begin
          taken = ((a == b) == (f3 == 3'd0));
          tgt   = pc + immb;
          if (!taken) ok = 1'b1;
          else if (tgt % 4 == 0) begin npc = tgt; ok = 1'b1; end
        end
        default: ;
      endcase
      if (!ok) begin
        e.halt = 1'b1;
        sb.push_back(e);
        return;
      end
      sb.push_back(e);
      if (wr && rdi != 0) r[rdi] = res;
      pc = npc;
    end
  endtask

  // Bus responder: grants after a chosen number of wait cycles, random grant outside MEM.
  always @(posedge clk) begin
    #1;
    if (bus_if.bus_req) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = 0;
        cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_target;
      end
      if ((stall_loads && !bus_if.bus_we) || wait_cnt < cur_wait) begin
        bus_if.bus_grant = 1'b0;
        wait_cnt++;
      end else begin
        bus_if.bus_grant = 1'b1;
      end
      bus_if.bus_rdata = dmem_rd(bus_if.bus_addr);
    end else begin
      in_txn           = 1'b0;
      bus_if.bus_grant = 1'($urandom_range(0, 1));
      bus_if.bus_rdata = $urandom;
    end
  end

  // Monitor: pops the scoreboard on retire/halt and checks every bus request cycle.
  always @(negedge clk) begin
    if (checking && !reset) begin
      if (retire) retire_cnt++;
      if (bus_if.bus_req) begin
        if (sb.size() == 0 || !sb[0].is_mem) begin
          fail_now("unexpected_bus_req",
                   $sformatf("got request at 0x%08h, expected no request", bus_if.bus_addr));
        end else begin
          checkOutput("bus_addr",   bus_if.bus_addr,       sb[0].addr);
          checkOutput("bus_we",     32'(bus_if.bus_we),    32'(sb[0].we));
          checkOutput("bus_wdata",  bus_if.bus_wdata,      sb[0].wdata);
          checkOutput("pc_frozen",  imem_addr,             sb[0].pc);
          if (bus_if.bus_grant && bus_if.bus_we) dmem[bus_if.bus_addr] = bus_if.bus_wdata;
        end
      end
      if (retire) begin
        if (sb.size() == 0 || sb[0].halt) begin
          fail_now("unexpected_retire", $sformatf("retire at pc 0x%08h, expected none", imem_addr));
        end else begin
          mon_e = sb.pop_front();
          checkOutput("retire_pc",   imem_addr, mon_e.pc);
          checkOutput("retire_kind", 32'(bus_if.bus_req && bus_if.bus_grant), 32'(mon_e.is_mem));
        end
      end
      if (halted) begin
        if (!halt_seen) begin
          halt_seen = 1'b1;
          if (sb.size() == 0 || !sb[0].halt) begin
            fail_now("unexpected_halt", $sformatf("halted at pc 0x%08h, expected running", imem_addr));
          end else begin
            mon_e   = sb.pop_front();
            halt_pc = mon_e.pc;
            checkOutput("halt_pc", imem_addr, mon_e.pc);
          end
        end else begin
          checkOutput("halt_pc_hold", imem_addr, halt_pc);
          checkOutput("halt_quiet", 32'({bus_if.bus_req, retire}), 32'h0);
        end
      end else if (halt_seen) begin
        fail_now("halt_dropped", "halted=0, expected sticky 1");
      end
    end
  end

  // Reset the core, check the reset values, then load the model's expectations.
  task automatic applyStimulus(input string tag);
    @(negedge clk);
    checking = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput({tag, ":rst_pc"},     imem_addr,                 RESET_PC);
    checkOutput({tag, ":rst_bus"},    32'({bus_if.bus_req, bus_if.bus_we}), 32'h0);
    checkOutput({tag, ":rst_addr"},   bus_if.bus_addr,           32'h0);
    checkOutput({tag, ":rst_wdata"},  bus_if.bus_wdata,          32'h0);
    checkOutput({tag, ":rst_status"}, 32'({retire, halted}),     32'h0);
    sb.delete();
    halt_seen  = 1'b0;
    retire_cnt = 0;
    iss_run();
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;
  endtask

  task automatic finish_program(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(sb.size() == 0 && halt_seen)) begin
      @(negedge clk);
      n++;
    end
    if (!(sb.size() == 0 && halt_seen))
      fail_now({tag, ":timeout"},
               $sformatf("%0d events pending, halted=%0b; expected all retired and halted",
                         sb.size(), halt_seen));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int k;
    logic found;
    n_vec = 0; n_err = 0; retire_cnt = 0;
    reset = 1'b1; checking = 1'b0; halt_seen = 1'b0; halt_pc = 32'h0;
    rand_wait = 1'b0; stall_loads = 1'b0; wait_target = 0;
    in_txn = 1'b0; wait_cnt = 0; cur_wait = 0;
    bus_if.bus_grant = 1'b0; bus_if.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // ALU chain and store through the core window, grant immediately
    clear_prog();
    emit(addi(1, 0, 5));
    emit(addi(2, 1, -7));
    emit(enc_r(7'h20, 2, 1, 3'b000, 3));
    emit(enc_s(0, 3, 0));
    applyStimulus("alu_store");
    repeat (9) @(posedge clk);
    #1;
    checkOutput("alu_store:retire_count_9cyc", 32'(retire_cnt), 32'd4);
    finish_program("alu_store", 60);

    // Delayed grant on a load, then store the loaded value
    clear_prog();
    preset(32'h18, 32'hDEAD_BEEF);
    emit(lw(4, 32'h10, 0));
    emit(enc_s(0, 4, 0));
    wait_target = 3;
    applyStimulus("delayed_grant");
    k = 0;
    while (k < 20 && !bus_if.bus_req) begin @(negedge clk); k++; end
    n = 0;
    while (bus_if.bus_req && n < 50) begin n++; @(negedge clk); end
    checkOutput("delayed_grant:req_cycles", 32'(n), 32'd4);
    finish_program("delayed_grant", 80);
    wait_target = 0;

    // Countdown loop with BNE, x0 write discard observed through a store
    clear_prog();
    emit(addi(1, 0, 3));
    emit(addi(1, 1, -1));
    emit(enc_b(-4, 0, 1, 3'b001));
    emit(enc_r(7'h00, 1, 1, 3'b000, 0));
    emit(enc_s(0, 0, 0));
    emit(enc_s(4, 1, 0));
    applyStimulus("branch_loop");
    finish_program("branch_loop", 100);

    // Halt cases
    clear_prog();
    applyStimulus("halt_ecall");
    finish_program("halt_ecall", 20);

    clear_prog();
    emit(lw(1, -6, 0));
    applyStimulus("halt_misaligned");
    finish_program("halt_misaligned", 20);

    clear_prog();
    emit(addi(1, 0, 9));
    emit(enc_r(7'h01, 1, 1, 3'b000, 2));
    applyStimulus("halt_funct7");
    finish_program("halt_funct7", 30);

    // Reset while a load is stalled in MEM
    clear_prog();
    emit(enc_s(4, 5, 0));
    emit(lw(5, 32'h20, 0));
    emit(enc_s(0, 5, 0));
    stall_loads = 1'b1;
    applyStimulus("rst_wait");
    found = 1'b0;
    k = 0;
    while (k < 40 && !found) begin
      @(negedge clk);
      k++;
      if (bus_if.bus_req && !bus_if.bus_we) found = 1'b1;
    end
    if (!found) fail_now("rst_wait:no_load_req", "no load request seen, expected one");
    repeat (2) @(negedge clk);
    checking = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("rst_wait:req_drop", 32'(bus_if.bus_req), 32'h0);
    checkOutput("rst_wait:addr_drop", bus_if.bus_addr, 32'h0);
    stall_loads = 1'b0;
    applyStimulus("rst_wait_restart");
    finish_program("rst_wait_restart", 60);

    // Random programs with random grant latency
    rand_wait = 1'b1;
    for (int p = 0; p < 25; p++) begin
      clear_prog();
      for (int i = 0; i < 16; i++) begin
        int kind, rd, rs1, rs2;
        kind = int'($urandom_range(0, 8));
        rd   = int'($urandom_range(0, 7));
        rs1  = int'($urandom_range(0, 7));
        rs2  = int'($urandom_range(0, 7));
        case (kind)
          0, 1, 2, 3: emit(enc_i(int'($urandom_range(0, 4095)) - 2048, rs1, pick_f3(), rd, 7'b0010011));
          4, 5, 6: begin
            if ($urandom_range(0, 3) == 0) emit(enc_r(7'h20, rs2, rs1, 3'b000, rd));
            else                           emit(enc_r(7'h00, rs2, rs1, pick_f3(), rd));
          end
          7:       emit(lw(rd, 4 * int'($urandom_range(0, 15)), 0));
          default: emit(enc_s(4 * int'($urandom_range(0, 15)), rs2, 0));
        endcase
      end
      applyStimulus($sformatf("rand%0d", p));
      finish_program($sformatf("rand%0d", p), 300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
